// File: rtl/led_show_seq_pkg.sv
// Shared types and constants for the LED chaser sequencer: FSM state
// encoding, mode/select widths and small helper functions.
package led_show_seq_pkg;

  localparam int MODE_W     = 2;
  localparam int SEL_W      = 2;
  localparam int MODE_COUNT = 4;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Counter width for a counter that must reach n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next pattern in the auto rotation, wrapping from the last mode back to 0
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
    return (m == MODE_W'(MODE_COUNT - 1)) ? '0 : m + MODE_W'(1);
  endfunction

endpackage

// File: rtl/led_timeout_cnt.sv
// Tick-enabled timeout counter with synchronous clear. It saturates at
// WRAP_TIMEOUT-1 and flags that terminal count so the sequencer can force
// a pending change when the pattern engine never reports a wrap.
module led_timeout_cnt
  import led_show_seq_pkg::*;
#(
  parameter int WRAP_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic term
);

  localparam int CNT_W = cnt_width(WRAP_TIMEOUT);

  logic [CNT_W-1:0] count;

  assign term = (count == CNT_W'(WRAP_TIMEOUT - 1));

  // Count ticks while enabled, holding at the terminal value
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (tick && !term) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_show_seq.sv
// Sequencer for the 8-LED chaser. Chooses the pattern mode and speed select
// fed to the pattern engine and divider mux, and only applies a change at a
// pattern wrap (or after a tick timeout) so the LEDs never jump mid-pattern.
// In auto mode it rotates through the four patterns, REPS wraps each.
module led_show_seq
  import led_show_seq_pkg::*;
#(
  parameter int REPS         = 4,
  parameter int WRAP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              pat_wrap,
  input  logic              en_auto,
  input  logic [MODE_W-1:0] sw_mode,
  input  logic [SEL_W-1:0]  sw_sel,
  output logic [MODE_W-1:0] mode,
  output logic [SEL_W-1:0]  sel,
  output logic              load,
  output logic              busy
);

  localparam int REP_W = cnt_width(REPS);

  state_t            state;
  logic [REP_W-1:0]  rep_cnt;
  logic              rep_last;
  logic              to_term;
  logic              sw_match;
  logic              auto_step;
  logic              enter_load;
  logic              enter_drain;
  logic [MODE_W-1:0] tgt_mode;

  // In auto mode the mode switch is ignored, so only the speed select can
  // request a change; in manual mode both switches must match what is applied.
  assign sw_match  = en_auto ? (sw_sel == sel)
                             : ((sw_mode == mode) && (sw_sel == sel));
  assign rep_last  = (rep_cnt == REP_W'(REPS - 1));
  assign auto_step = en_auto && pat_wrap && rep_last;

  // LOAD with load still low only happens on the first edge after reset,
  // which is where the power-on load is performed.
  assign enter_load =
      ((state == S_LOAD) && !load) ||
      ((state == S_RUN) && (auto_step || (!sw_match && pat_wrap))) ||
      ((state == S_DRAIN) && !sw_match && (pat_wrap || (tick && to_term)));

  assign enter_drain = (state == S_RUN) && !auto_step && !sw_match && !pat_wrap;

  assign tgt_mode = !en_auto ? sw_mode :
                    (((state == S_RUN) && auto_step) || (state == S_LOAD)) ? next_mode(mode) :
                    mode;

  led_timeout_cnt #(
    .WRAP_TIMEOUT(WRAP_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state != S_DRAIN),
    .tick  (tick),
    .term  (to_term)
  );

  // Sequencer FSM with registered mode/sel/load/busy and the repetition counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_LOAD;
      mode    <= '0;
      sel     <= '0;
      load    <= 1'b0;
      busy    <= 1'b1;
      rep_cnt <= '0;
    end else begin
      load <= 1'b0;
      if (enter_load) begin
        state   <= S_LOAD;
        mode    <= tgt_mode;
        sel     <= sw_sel;
        load    <= 1'b1;
        busy    <= 1'b1;
        rep_cnt <= '0;
      end else begin
        case (state)
          S_LOAD: begin
            state   <= S_RUN;
            busy    <= 1'b0;
            rep_cnt <= '0;
          end
          S_RUN: begin
            if (enter_drain) begin
              state <= S_DRAIN;
              busy  <= 1'b1;
            end else if (en_auto && pat_wrap) begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
          S_DRAIN: begin
            if (sw_match) begin
              state <= S_RUN;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        endcase
      end
      if (!en_auto) begin
        rep_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_show_seq.sv
// Self-checking bench for led_show_seq: directed scenarios followed by
// randomized traffic, with a behavioural model feeding a load scoreboard.
module tb_led_show_seq;

  localparam int REPS = 4;
  localparam int WT   = 16;

  typedef struct {
    int mode;
    int sel;
  } load_t;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       pat_wrap;
  logic       en_auto;
  logic [1:0] sw_mode;
  logic [1:0] sw_sel;
  logic [1:0] mode;
  logic [1:0] sel;
  logic       load;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;

  // Reference view: what is applied, whether a change is waiting for a
  // wrap, whether this cycle shows the load pulse, and how long we waited.
  int  m_mode    = 0;
  int  m_sel     = 0;
  bit  m_fresh   = 1;
  bit  m_loading = 0;
  bit  m_pending = 0;
  int  m_ticks   = 0;
  int  m_wraps   = 0;
  load_t sb_q[$];

  led_show_seq #(
    .REPS         (REPS),
    .WRAP_TIMEOUT (WT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .pat_wrap (pat_wrap),
    .en_auto  (en_auto),
    .sw_mode  (sw_mode),
    .sw_sel   (sw_sel),
    .mode     (mode),
    .sel      (sel),
    .load     (load),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_apply(input int new_mode, input int new_sel);
    load_t e;
    m_mode    = new_mode;
    m_sel     = new_sel;
    m_fresh   = 0;
    m_loading = 1;
    m_pending = 0;
    m_ticks   = 0;
    m_wraps   = 0;
    e.mode = new_mode;
    e.sel  = new_sel;
    sb_q.push_back(e);
  endtask

  // Reference model: advance one clock using the inputs held before the edge
  always @(posedge clk) begin : model
    int  want_mode;
    bit  differ;
    if (!reset) begin
      m_mode = 0; m_sel = 0; m_fresh = 1; m_loading = 0;
      m_pending = 0; m_ticks = 0; m_wraps = 0;
      sb_q.delete();
    end else begin
      want_mode = en_auto ? m_mode : int'(sw_mode);
      differ    = (want_mode != m_mode) || (int'(sw_sel) != m_sel);
      if (m_fresh) begin
        model_apply(en_auto ? (m_mode + 1) % 4 : int'(sw_mode), int'(sw_sel));
      end else if (m_loading) begin
        m_loading = 0;
      end else if (!m_pending && en_auto && pat_wrap && m_wraps == REPS - 1) begin
        model_apply((m_mode + 1) % 4, int'(sw_sel));
      end else if (differ) begin
        if (pat_wrap || (m_pending && tick && m_ticks == WT - 1))
          model_apply(want_mode, int'(sw_sel));
        else if (m_pending)
          m_ticks = m_ticks + (tick ? 1 : 0);
        else begin
          m_pending = 1;
          m_ticks   = 0;
        end
      end else begin
        if (!m_pending && en_auto && pat_wrap) m_wraps++;
        m_pending = 0;
      end
      if (!en_auto) m_wraps = 0;
    end
  end

  // Monitor: compare outputs every cycle and pop the scoreboard on each load
  always @(negedge clk) begin
    load_t e;
    if (mon_en) begin
      check_output("busy", busy, m_fresh || m_loading || m_pending);
      check_output("load", load, m_loading);
      check_output("mode", mode, m_mode);
      check_output("sel", sel, m_sel);
      if (load === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL sb_unexpected_load: got load=1 expected no pending entry at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check_output("sb_mode", mode, e.mode);
          check_output("sb_sel", sel, e.sel);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic rst_n, input logic auto_en, input logic [1:0] smode,
                                input logic [1:0] ssel, input logic tk, input logic wr);
    reset    = rst_n;
    en_auto  = auto_en;
    sw_mode  = smode;
    sw_sel   = ssel;
    tick     = tk;
    pat_wrap = wr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       r_auto;
    logic [1:0] r_mode;
    logic [1:0] r_sel;
    int         wrap_div;
    int         load_seen;

    // Reset held for three cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      mon_en = 1;
      check_output("rst_mode", mode, 0);
      check_output("rst_sel", sel, 0);
      check_output("rst_load", load, 0);
      check_output("rst_busy", busy, 1);
    end
    apply_stimulus(1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0);
    check_output("post_rst_load", load, 1);
    check_output("post_rst_mode", mode, 1);
    check_output("post_rst_sel", sel, 0);
    apply_stimulus(1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0);
    check_output("post_rst_busy", busy, 0);
    check_output("post_rst_load_end", load, 0);

    // Manual change held until a wrap three ticks later
    apply_stimulus(1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0);
    check_output("man_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0);
      check_output("man_no_early_load", load, 0);
    end
    apply_stimulus(1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b1);
    check_output("man_load", load, 1);
    check_output("man_mode", mode, 2);
    apply_stimulus(1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0);

    // Timeout: no wrap ever arrives, load lands right after the 16th tick
    apply_stimulus(1'b1, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0);
    for (int i = 1; i <= WT; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'd2, 2'd3, 1'b1, 1'b0);
      check_output("to_load", load, (i == WT) ? 1 : 0);
    end
    check_output("to_sel", sel, 3);
    apply_stimulus(1'b1, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0);

    // Auto rotation starting from mode 3
    apply_stimulus(1'b1, 1'b0, 2'd3, 2'd3, 1'b0, 1'b1);
    check_output("auto_pre_mode", mode, 3);
    apply_stimulus(1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0);
    for (int k = 1; k <= 4 * REPS; k++) begin
      apply_stimulus(1'b1, 1'b1, 2'($urandom), 2'd3, 1'b0, 1'b1);
      check_output("auto_load", load, (k % REPS == 0) ? 1 : 0);
      check_output("auto_mode", mode, (3 + k / REPS) % 4);
      apply_stimulus(1'b1, 1'b1, 2'($urandom), 2'd3, 1'b1, 1'b0);
    end

    // Change coinciding with a wrap loads without draining
    apply_stimulus(1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1);
    check_output("edge_wrap_load", load, 1);
    check_output("edge_wrap_mode", mode, 0);
    apply_stimulus(1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
    check_output("edge_wrap_busy", busy, 0);

    // Revert during drain returns to run with no load
    apply_stimulus(1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0);
    check_output("revert_busy_in", busy, 1);
    apply_stimulus(1'b1, 1'b0, 2'd1, 2'd3, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0);
    check_output("revert_busy_out", busy, 0);
    check_output("revert_load", load, 0);
    apply_stimulus(1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1);
    check_output("revert_mode", mode, 0);

    // Reset in the middle of a drain with seven ticks counted
    apply_stimulus(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1);
    check_output("mid_rst_mode", mode, 0);
    check_output("mid_rst_sel", sel, 0);
    check_output("mid_rst_load", load, 0);
    check_output("mid_rst_busy", busy, 1);
    apply_stimulus(1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0);
    load_seen = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'd2, 2'd1, 1'(i % 2), 1'b0);
      if (load === 1'b1) load_seen++;
    end
    check_output("mid_rst_load_count", load_seen, 1);
    check_output("mid_rst_sel_after", sel, 1);

    // Randomized traffic, with the wrap rate varied to exercise timeouts
    r_auto = 1'b0;
    r_mode = 2'd2;
    r_sel  = 2'd1;
    wrap_div = 6;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) wrap_div = (($urandom % 3) == 0) ? 0 : (($urandom % 2) == 0) ? 6 : 40;
      if ($urandom_range(59, 0) == 0) r_auto = ~r_auto;
      if ($urandom_range(19, 0) == 0) r_mode = 2'($urandom);
      if ($urandom_range(24, 0) == 0) r_sel  = 2'($urandom);
      apply_stimulus(($urandom_range(149, 0) == 0) ? 1'b0 : 1'b1, r_auto, r_mode, r_sel,
                     1'($urandom), (wrap_div != 0) && ($urandom_range(wrap_div - 1, 0) == 0));
    end

    apply_stimulus(1'b1, r_auto, r_mode, r_sel, 1'b0, 1'b0);
    apply_stimulus(1'b1, r_auto, r_mode, r_sel, 1'b0, 1'b0);
    @(negedge clk);
    mon_en = 0;
    check_output("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
